// File: rtl/ahb3_lite_sram_slave_if.sv
// ahb3_lite_sram_slave_if: AHB3-Lite bus bundle seen from the SRAM slave
interface ahb3_lite_sram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              hsel_i;
  logic [ADDR_W-1:0] haddr_i;
  logic [1:0]        htrans_i;
  logic              hwrite_i;
  logic [2:0]        hsize_i;
  logic [2:0]        hburst_i;
  logic [3:0]        hprot_i;
  logic              hmastlock_i;
  logic [DATA_W-1:0] hwdata_i;
  logic              hready_i;
  logic [DATA_W-1:0] hrdata_o;
  logic              hready_o;
  logic              hresp_o;
  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           hmastlock_i, hwdata_i, hready_i,
    output hrdata_o, hready_o, hresp_o
  );
  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           hmastlock_i, hwdata_i, hready_i,
    input  hrdata_o, hready_o, hresp_o
  );
endinterface

// File: rtl/ahb3_lite_sram_slave.sv
// ahb3_lite_sram_slave: AHB3-Lite scratch SRAM with wait states, lane writes and ERROR response
module ahb3_lite_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  ahb3_lite_sram_slave_if.slave bus
);
  localparam int BW = DATA_W / 8;
  localparam int LB = $clog2(BW);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     word_q;
  logic [BW-1:0]     be_q, be_d;
  logic              write_q;
  logic [LB-1:0]     amask;
  logic              open, accept, err;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_ok;

  assign unused_ok = ^{bus.hburst_i, bus.hprot_i, bus.hmastlock_i};
  // A new address phase can only land where the previous data phase is ending (or none is pending)
  assign open   = state_q inside {S_IDLE, S_DATA, S_ERR2};
  assign accept = open & bus.hsel_i & bus.htrans_i[1] & bus.hready_i;
  assign amask  = ~({LB{1'b1}} << bus.hsize_i);
  assign err    = (bus.hsize_i > 3'(LB)) | (|(bus.haddr_i[LB-1:0] & amask)) |
                  ((bus.haddr_i >> LB) >= ADDR_W'(DEPTH));
  assign be_d   = ~({BW{1'b1}} << (4'd1 << bus.hsize_i)) << bus.haddr_i[LB-1:0];

  // Next state and wait counter; ERR1 always advances to ERR2
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = err ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_DATA);
      cnt_d   = WLOAD;
    end else if (open) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      state_d = cnt_q == 4'd0 ? S_DATA : S_WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else begin
      state_d = S_ERR2;
    end
  end

  // State register plus the captured address-phase controls
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q  <= bus.haddr_i[LB +: IW];
        be_q    <= be_d;
        write_q <= bus.hwrite_i;
      end
    end
  end

  // Commit enabled lanes on the edge that ends an OKAY write data phase; reset leaves contents alone
  always_ff @(posedge clk_i) begin
    if (state_q == S_DATA && write_q)
      for (int b = 0; b < BW; b++)
        if (be_q[b]) mem[word_q][8*b +: 8] <= bus.hwdata_i[8*b +: 8];
  end

  assign bus.hready_o = !(state_q == S_WAIT || state_q == S_ERR1);
  assign bus.hresp_o  = state_q == S_ERR1 || state_q == S_ERR2;
  assign bus.hrdata_o = (state_q == S_DATA && !write_q) ? mem[word_q] : '0;
endmodule
